// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with a multi-cycle mult/div sequencer.
//
// Decodes opcode/funct into a registered ALU select. Mult/div instructions launch a
// sequencer that occupies the datapath for MD_CYCLES cycles, then pulses hilo_we.
// Instructions that depend on HI/LO (MD, MFHI, MFLO) stall while the sequencer is busy.
//
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - synchronous active-low reset
//   valid_i   - decode stage presents an instruction
//   opcode    - instruction opcode
//   funct     - R-type function field (used only when opcode == 0)
//   sel       - registered ALU select
//   sel_valid - sel belongs to an instruction accepted last cycle
//   stall     - combinational; decode must hold its instruction
//   md_start  - one-cycle launch pulse for the mult/div datapath
//   md_op     - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; held while busy
//   md_busy   - sequencer not idle
//   hilo_we   - one-cycle pulse to write the mult/div result into HI/LO
module alu_ctrl_seq #(
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    output logic [SEL_W-1:0] sel,
    output logic             sel_valid,
    output logic             stall,
    output logic             md_start,
    output logic [1:0]       md_op,
    output logic             md_busy,
    output logic             hilo_we
);

    localparam logic [SEL_W-1:0] SelAnd  = SEL_W'(0);
    localparam logic [SEL_W-1:0] SelOr   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SelAdd  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SelSub  = SEL_W'(3);
    localparam logic [SEL_W-1:0] SelSlt  = SEL_W'(4);
    localparam logic [SEL_W-1:0] SelSll  = SEL_W'(5);
    localparam logic [SEL_W-1:0] SelSrl  = SEL_W'(6);
    localparam logic [SEL_W-1:0] SelSra  = SEL_W'(7);
    localparam logic [SEL_W-1:0] SelLui  = SEL_W'(8);
    localparam logic [SEL_W-1:0] SelXor  = SEL_W'(9);
    localparam logic [SEL_W-1:0] SelNor  = SEL_W'(10);
    localparam logic [SEL_W-1:0] SelSltu = SEL_W'(11);
    localparam logic [SEL_W-1:0] SelMd   = SEL_W'(12);
    localparam logic [SEL_W-1:0] SelMfhi = SEL_W'(13);
    localparam logic [SEL_W-1:0] SelMflo = SEL_W'(14);
    localparam logic [SEL_W-1:0] SelNop  = SEL_W'(15);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               sel_valid_q, sel_valid_d;
    logic               md_start_q, md_start_d;
    logic [1:0]         md_op_q, md_op_d;
    logic               md_busy_q, md_busy_d;
    logic               hilo_we_q, hilo_we_d;

    logic [SEL_W-1:0]   dec_sel;
    logic               is_md;
    logic               uses_hilo;
    logic               accept;

    // Instruction decode
    always_comb begin
        dec_sel = SelNop;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: dec_sel = SelAdd;
                    6'b100010: dec_sel = SelSub;
                    6'b100100: dec_sel = SelAnd;
                    6'b100101: dec_sel = SelOr;
                    6'b100110: dec_sel = SelXor;
                    6'b100111: dec_sel = SelNor;
                    6'b101010: dec_sel = SelSlt;
                    6'b101011: dec_sel = SelSltu;
                    6'b000000: dec_sel = SelSll;
                    6'b000010: dec_sel = SelSrl;
                    6'b000011: dec_sel = SelSra;
                    6'b010000: dec_sel = SelMfhi;
                    6'b010010: dec_sel = SelMflo;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_sel = SelMd;
                    default:   dec_sel = SelNop;
                endcase
            end
            6'b001000: dec_sel = SelAdd;
            6'b001100: dec_sel = SelAnd;
            6'b001101: dec_sel = SelOr;
            6'b001110: dec_sel = SelXor;
            6'b001010: dec_sel = SelSlt;
            6'b001011: dec_sel = SelSltu;
            6'b001111: dec_sel = SelLui;
            6'b000100, 6'b000101: dec_sel = SelSub;
            // loads and stores use the adder for address generation
            6'b100000, 6'b100001, 6'b100011,
            6'b101000, 6'b101001, 6'b101011: dec_sel = SelAdd;
            default:   dec_sel = SelNop;
        endcase
    end

    assign is_md     = (dec_sel == SelMd);
    assign uses_hilo = is_md || (dec_sel == SelMfhi) || (dec_sel == SelMflo);
    // Busy covers DONE too, so HI/LO readers wait until the write has landed
    assign stall     = valid_i && md_busy_q && uses_hilo;
    assign accept    = valid_i && !stall;

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        md_op_d     = md_op_q;
        md_busy_d   = md_busy_q;
        md_start_d  = 1'b0;
        hilo_we_d   = 1'b0;
        sel_valid_d = accept;
        sel_d       = accept ? dec_sel : sel_q;

        case (state_q)
            StIdle: begin
                if (accept && is_md) begin
                    md_op_d    = funct[1:0];
                    md_start_d = 1'b1;
                    cnt_d      = CNT_W'(MD_CYCLES - 1);
                    md_busy_d  = 1'b1;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    hilo_we_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                md_busy_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                md_busy_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= SelNop;
            sel_valid_q <= 1'b0;
            md_start_q  <= 1'b0;
            md_op_q     <= 2'b00;
            md_busy_q   <= 1'b0;
            hilo_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            md_start_q  <= md_start_d;
            md_op_q     <= md_op_d;
            md_busy_q   <= md_busy_d;
            hilo_we_q   <= hilo_we_d;
        end
    end

    assign sel       = sel_q;
    assign sel_valid = sel_valid_q;
    assign md_start  = md_start_q;
    assign md_op     = md_op_q;
    assign md_busy   = md_busy_q;
    assign hilo_we   = hilo_we_q;

endmodule
